conv_result_packer: RTL and testbench
=====================================

CONV_RESULT_PACKER -- requirements
Module: conv_result_packer

Interface
REQ-001 SHALL have parameter B_PIXEL, default 16, width of one partial-sum pixel.
REQ-002 SHALL have parameter N_INST, default 32, width of the instruction tag travelling with the DSP chain.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, output word width; 4 pixels per word.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, output FIFO depth in words; power of two.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port partial_sum_i, input, B_PIXEL, pixel from the last DSP group of the conv unit chain.
REQ-008 SHALL have port inst_i, input, N_INST, tag aligned with partial_sum_i; bit0 = pixel valid, bit1 = last pixel of frame, other bits ignored.
REQ-009 SHALL have port m_data, output, DATA_WIDTH, packed result word toward the DDR writer.
REQ-010 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_last (output, 1, final word of frame).
REQ-011 SHALL have ports word_cnt (output, 32, words popped since reset), overflow (output, 1, sticky) and frame_done (output, 1, pulse).

Function
REQ-012 SHALL capture partial_sum_i only in cycles where inst_i[0]=1; the input has no backpressure.
REQ-013 SHALL place pixel k of a word in lane k at bits [16k+15:16k]; the first pixel of a word goes in lane 0.
REQ-014 SHALL keep a 2-bit lane counter that advances on each valid pixel and wraps 3->0.
REQ-015 SHALL complete a word when the lane-3 pixel is captured, or when a pixel with inst_i[1]=1 is captured in any lane.
REQ-016 SHALL zero-fill unused upper lanes of a word completed by inst_i[1] and set that word's m_last=1; the lane counter then returns to 0.
REQ-017 SHALL register a completed word at the edge ending its final-pixel cycle t, and push it into the FIFO at edge t+1.
REQ-018 SHALL drive m_valid in cycle t+2 when the FIFO was empty, giving a fixed 2-cycle input-to-output latency.
REQ-019 SHALL keep m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-020 SHALL pop the FIFO on m_valid & m_ready and, in the same cycle, increment word_cnt (wrapping at 2^32).
REQ-021 SHALL accept a push when the FIFO is full if a pop occurs in the same cycle; the occupancy is then unchanged.
REQ-022 SHALL drop a pushed word when the FIFO is full and no pop occurs in that cycle, and set overflow=1 until reset.
REQ-023 SHALL pulse frame_done for exactly one cycle, in the cycle after a word with m_last=1 is popped.
REQ-024 SHALL continue accepting valid pixels while a completed word waits to be pushed; back-to-back valid pixels at full rate are sustained.
REQ-025 SHALL treat inst_i[1]=1 with inst_i[0]=0 as a no-op.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, clear the lane counter, pack register, pending-push flag, FIFO pointers and occupancy, and word_cnt to 0.
REQ-027 SHALL reset overflow to 0, frame_done to 0, m_valid to 0, m_last to 0 and m_data to 0.
REQ-028 SHALL discard any partially packed word and all FIFO contents when reset is asserted mid-frame; the first valid pixel after reset goes in lane 0.

Structure
REQ-029 SHALL take the inst bit positions (VALID=0, LAST=1) and the pixels-per-word constant from the shared conv package, which is also used by conv unit and dsp group.
REQ-030 SHALL implement the output buffer as one sub-module, result_fifo: a synchronous single-clock FIFO with show-ahead output and full/empty flags.

Verification
REQ-031 SHALL cover packing: pixels 0x0001, 0x0002, 0x0003, 0x0004 sent on consecutive valid cycles -> m_data=0x0004_0003_0002_0001 and m_last=0, first valid 2 cycles after the fourth pixel.
REQ-032 SHALL cover partial flush: pixels 0xAAAA, 0xBBBB, the second with inst_i[1]=1 -> m_data=0x0000_0000_BBBB_AAAA, m_last=1, then frame_done pulses once after the pop.
REQ-033 SHALL cover backpressure: m_ready=0 while 16 full words are packed, then a 17th word completes -> overflow=1 and 16 words pop in order with word_cnt=16.
REQ-034 SHALL cover simultaneous push and pop: FIFO full and m_ready=1 when a new word is pushed -> no overflow and occupancy stays 16.
REQ-035 SHALL cover gaps and reset: valid pixels with idle cycles between them produce the same words as the gap-free case, and rst asserted after 2 pixels leaves word_cnt=0 with the next 4 pixels packed from lane 0.

Source files
------------

// File: rtl/conv_result_packer_pkg.sv
// Shared conv constants: instruction tag bit positions and pixels per packed word.
// Also used by the conv unit and dsp group so all stages agree on the tag layout.
package conv_result_packer_pkg;

   localparam int INST_VALID   = 0;
   localparam int INST_LAST    = 1;
   localparam int PIX_PER_WORD = 4;
   localparam int LANE_W       = $clog2(PIX_PER_WORD);

   typedef logic [LANE_W-1:0] lane_t;

endpackage

// File: rtl/conv_result_packer_result_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags.
// A write while full is accepted only if a read frees a slot in the same cycle.
module result_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);

   // Empty reads as zero so the packer's outputs are clean after reset.
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/conv_result_packer.sv
// Packs valid pixels from the last DSP group into 4-lane words and buffers them
// toward the DDR writer; a frame-last pixel flushes a zero-filled partial word.
module conv_result_packer
   import conv_result_packer_pkg::*;
#(
   parameter int B_PIXEL    = 16,
   parameter int N_INST     = 32,
   parameter int DATA_WIDTH = 64,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [B_PIXEL-1:0]    partial_sum_i,
   input  logic [N_INST-1:0]     inst_i,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic [31:0]           word_cnt,
   output logic                  overflow,
   output logic                  frame_done
);

   lane_t                 lane;
   logic [DATA_WIDTH-1:0] pack_reg;
   logic [DATA_WIDTH-1:0] next_word;
   logic [DATA_WIDTH-1:0] done_word;
   logic                  done_last;
   logic                  pending;
   logic                  pix_valid;
   logic                  pix_last;
   logic                  word_complete;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  unused_inst_bits;

   assign pix_valid        = inst_i[INST_VALID];
   assign pix_last         = inst_i[INST_LAST];
   assign unused_inst_bits = ^inst_i;
   assign word_complete    = pix_valid & (pix_last || lane == lane_t'(PIX_PER_WORD - 1));

   always_comb begin
      next_word = pack_reg;
      next_word[int'(lane) * B_PIXEL +: B_PIXEL] = partial_sum_i;
   end

   // The pack register is cleared on completion, so a flushed word's upper lanes are already zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         lane      <= '0;
         pack_reg  <= '0;
         done_word <= '0;
         done_last <= 1'b0;
         pending   <= 1'b0;
      end else begin
         pending <= word_complete;
         if (word_complete) begin
            done_word <= next_word;
            done_last <= pix_last;
            pack_reg  <= '0;
            lane      <= '0;
         end else if (pix_valid) begin
            pack_reg <= next_word;
            lane     <= lane + 1'b1;
         end
      end
   end

   result_fifo #(
      .WIDTH(DATA_WIDTH + 1),
      .DEPTH(FIFO_DEPTH)
   ) u_result_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (pending),
      .wr_data({done_last, done_word}),
      .rd_en  (pop),
      .rd_data({m_last, m_data}),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign m_valid = ~fifo_empty;
   assign pop     = m_valid & m_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt   <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         word_cnt   <= word_cnt + 32'(pop);
         frame_done <= pop & m_last;
         if (pending & fifo_full & ~pop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_conv_result_packer.sv
// Directed and randomized checks of conv_result_packer against a queue-based
// model that groups pixels into words by count and frame-last flag.
module tb_conv_result_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] partial_sum_i;
   logic [31:0] inst_i;
   logic [63:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic [31:0] word_cnt;
   logic        overflow;
   logic        frame_done;

   int          checks = 0;
   int          errors = 0;
   int          fd_count = 0;
   logic        ready_level = 1'b0;
   logic [64:0] exp_q[$];
   logic [64:0] got_q[$];
   logic [15:0] model_pix[$];

   conv_result_packer dut (
      .clk          (clk),
      .rst          (rst),
      .partial_sum_i(partial_sum_i),
      .inst_i       (inst_i),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_last       (m_last),
      .word_cnt     (word_cnt),
      .overflow     (overflow),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) got_q.push_back({m_last, m_data});
      if (!rst && frame_done) fd_count++;
   end

   task automatic checkOutput(input string tag, input logic [64:0] observed, input logic [64:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic l, input logic [15:0] px, input logic rdy);
      @(posedge clk);
      #1;
      inst_i        = {30'b0, l, v};
      partial_sum_i = px;
      m_ready       = rdy;
   endtask

   // Reference: a word is formed from 4 collected pixels, or fewer when one is frame-last.
   task automatic modelPixel(input logic [15:0] px, input logic last);
      logic [63:0] w;
      model_pix.push_back(px);
      if (model_pix.size() == 4 || last) begin
         w = '0;
         foreach (model_pix[i]) w[16*i +: 16] = model_pix[i];
         exp_q.push_back({last, w});
         model_pix.delete();
      end
   endtask

   task automatic sendPixel(input logic [15:0] px, input logic last);
      applyStimulus(1'b1, last, px, ready_level);
      modelPixel(px, last);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), ready_level);
   endtask

   task automatic resetDut();
      @(posedge clk);
      #1;
      rst           = 1'b1;
      inst_i        = '0;
      partial_sum_i = '0;
      ready_level   = 1'b0;
      m_ready       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      got_q.delete();
      model_pix.delete();
      fd_count = 0;
   endtask

   task automatic drainAll(input string tag);
      int n;
      int lasts;
      ready_level = 1'b1;
      idle(3);
      n = 0;
      while (m_valid && n < 400) begin
         idle(1);
         n++;
      end
      idle(2);
      checkOutput({tag, "_drained"}, m_valid, 1'b0);
      checkOutput({tag, "_n_words"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         checkOutput($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
      checkOutput({tag, "_word_cnt"}, word_cnt, exp_q.size());
      lasts = 0;
      foreach (exp_q[i]) if (exp_q[i][64]) lasts++;
      checkOutput({tag, "_frame_done_cnt"}, fd_count, lasts);
   endtask

   initial begin
      int base;
      rst           = 1'b1;
      inst_i        = '0;
      partial_sum_i = '0;
      m_ready       = 1'b0;

      // Reset state
      resetDut();
      checkOutput("rst_m_valid", m_valid, 1'b0);
      checkOutput("rst_m_data", m_data, 64'h0);
      checkOutput("rst_m_last", m_last, 1'b0);
      checkOutput("rst_word_cnt", word_cnt, 32'h0);
      checkOutput("rst_overflow", overflow, 1'b0);
      checkOutput("rst_frame_done", frame_done, 1'b0);

      // Four pixels into one word with 2-cycle latency
      ready_level = 1'b1;
      sendPixel(16'h0001, 1'b0);
      sendPixel(16'h0002, 1'b0);
      sendPixel(16'h0003, 1'b0);
      sendPixel(16'h0004, 1'b0);
      idle(1);
      checkOutput("pack_valid_t1", m_valid, 1'b0);
      idle(1);
      checkOutput("pack_valid_t2", m_valid, 1'b1);
      checkOutput("pack_word", {m_last, m_data}, {1'b0, 64'h0004_0003_0002_0001});
      drainAll("pack");

      // Partial flush with frame-last, then frame_done pulse
      resetDut();
      sendPixel(16'hAAAA, 1'b0);
      sendPixel(16'hBBBB, 1'b1);
      idle(2);
      checkOutput("flush_valid", m_valid, 1'b1);
      checkOutput("flush_word", {m_last, m_data}, {1'b1, 64'h0000_0000_BBBB_AAAA});
      checkOutput("flush_hold", {m_last, m_data}, {1'b1, 64'h0000_0000_BBBB_AAAA});
      checkOutput("flush_fd_before", frame_done, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
      checkOutput("flush_fd_pulse", frame_done, 1'b1);
      checkOutput("flush_valid_after", m_valid, 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
      checkOutput("flush_fd_single", frame_done, 1'b0);
      drainAll("flush");

      // Backpressure: 16 words fill the buffer, the 17th is dropped
      resetDut();
      for (int i = 0; i < 64; i++) sendPixel(16'($urandom), 1'b0);
      idle(2);
      checkOutput("bp_no_ovf_at_16", overflow, 1'b0);
      checkOutput("bp_valid", m_valid, 1'b1);
      for (int i = 0; i < 4; i++) sendPixel(16'($urandom), 1'b0);
      idle(2);
      checkOutput("bp_ovf", overflow, 1'b1);
      void'(exp_q.pop_back());
      drainAll("bp");
      checkOutput("bp_ovf_sticky", overflow, 1'b1);

      // Push into a full buffer while popping
      resetDut();
      for (int i = 0; i < 68; i++) sendPixel(16'($urandom), 1'b0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      idle(3);
      checkOutput("simul_no_ovf", overflow, 1'b0);
      checkOutput("simul_one_popped", got_q.size(), 1);
      base = got_q.size();
      drainAll("simul");
      checkOutput("simul_occupancy", got_q.size() - base, 16);

      // Idle gaps, including last-flag-without-valid no-ops
      resetDut();
      ready_level = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         sendPixel(16'(i), 1'b0);
         idle($urandom_range(0, 3));
      end
      drainAll("gaps");
      checkOutput("gaps_word", got_q.size() > 0 ? got_q[0] : 65'bx, {1'b0, 64'h0004_0003_0002_0001});

      // Reset mid-frame discards the partial word
      sendPixel(16'h1111, 1'b0);
      sendPixel(16'h2222, 1'b0);
      resetDut();
      checkOutput("midrst_word_cnt", word_cnt, 32'h0);
      for (int i = 5; i <= 8; i++) sendPixel(16'(i), 1'b0);
      drainAll("midrst");
      checkOutput("midrst_word", got_q.size() > 0 ? got_q[0] : 65'bx, {1'b0, 64'h0008_0007_0006_0005});

      // Randomized traffic with random backpressure
      resetDut();
      for (int c = 0; c < 400; c++) begin
         logic v;
         logic l;
         logic [15:0] px;
         v  = 1'($urandom_range(0, 1));
         l  = ($urandom_range(0, 7) == 0);
         px = 16'($urandom);
         applyStimulus(v, l, px, $urandom_range(0, 3) != 0);
         if (v) modelPixel(px, l);
      end
      sendPixel(16'($urandom), 1'b1);
      drainAll("rand");
      checkOutput("rand_no_ovf", overflow, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
